// File: rtl/counter_sequencer.sv
// rtl/counter_sequencer.sv - command-driven prescaled step counter (LOAD/RUN_UP/RUN_DOWN/BOUNCE)
module counter_sequencer #(
    parameter int WIDTH    = 3,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_arg,
    input  logic             abort,
    output logic [WIDTH-1:0] n,
    output logic             forward,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    localparam logic [WIDTH-1:0] MAX   = '1;
    localparam int               PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]    PLAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
    typedef enum logic [1:0] {OP_LOAD, OP_UP, OP_DOWN, OP_BOUNCE} op_t;

    state_t           state;
    op_t              op;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] remaining;
    logic [PW-1:0]    pcount;
    logic [WIDTH-1:0] n_inc;
    logic [WIDTH-1:0] n_dec;

    assign n_inc     = n + 1'b1;
    assign n_dec     = n - 1'b1;
    assign cmd_ready = (state == IDLE) && !reset;
    assign busy      = (state == RUN);
    assign done      = (state == FINISH);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            op        <= OP_LOAD;
            target    <= '0;
            remaining <= '0;
            pcount    <= '0;
            n         <= '0;
            forward   <= 1'b1;
            aborted   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op        <= op_t'(cmd_op);
                        target    <= cmd_arg;
                        remaining <= cmd_arg;
                        pcount    <= '0;
                        case (op_t'(cmd_op))
                            OP_LOAD: begin
                                n     <= cmd_arg;
                                state <= FINISH;
                            end
                            OP_UP: begin
                                forward <= 1'b1;
                                state   <= (n == cmd_arg) ? FINISH : RUN;
                            end
                            OP_DOWN: begin
                                forward <= 1'b0;
                                state   <= (n == cmd_arg) ? FINISH : RUN;
                            end
                            default: begin
                                state <= (cmd_arg == '0) ? FINISH : RUN;
                            end
                        endcase
                    end
                end
                RUN: begin
                    // abort wins over a tick landing on the same edge
                    if (abort) begin
                        aborted <= 1'b1;
                        state   <= FINISH;
                    end else if (pcount == PLAST) begin
                        pcount <= '0;
                        case (op)
                            OP_UP: begin
                                n <= n_inc;
                                if (n_inc == target) state <= FINISH;
                            end
                            OP_DOWN: begin
                                n <= n_dec;
                                if (n_dec == target) state <= FINISH;
                            end
                            OP_BOUNCE: begin
                                if (n == MAX) begin
                                    n         <= MAX - 1'b1;
                                    forward   <= 1'b0;
                                    remaining <= remaining - 1'b1;
                                    if (remaining == WIDTH'(1)) state <= FINISH;
                                end else if (n == '0) begin
                                    n         <= WIDTH'(1);
                                    forward   <= 1'b1;
                                    remaining <= remaining - 1'b1;
                                    if (remaining == WIDTH'(1)) state <= FINISH;
                                end else begin
                                    n <= forward ? n_inc : n_dec;
                                end
                            end
                            default: state <= FINISH;
                        endcase
                    end else begin
                        pcount <= pcount + 1'b1;
                    end
                end
                FINISH: begin
                    aborted <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_counter_sequencer.sv
// tb/tb_counter_sequencer.sv - directed self-checking bench for counter_sequencer
module tb_counter_sequencer;

    localparam int W = 3;
    localparam int P = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [W-1:0] cmd_arg;
    logic         abort;
    logic [W-1:0] n;
    logic         forward;
    logic         busy;
    logic         done;
    logic         aborted;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] seen [16];
    logic [W-1:0] exp_up [4]      = '{3'd6, 3'd7, 3'd0, 3'd1};
    logic [W-1:0] exp_bounce [10] = '{3'd6, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1};

    counter_sequencer #(.WIDTH(W), .PRESCALE(P)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_arg   (cmd_arg),
        .abort     (abort),
        .n         (n),
        .forward   (forward),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [W-1:0] arg);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic run_collect(output int nsteps, output int busy_cnt,
                               output bit timing_ok, output bit finished);
        logic [W-1:0] prev;
        nsteps = 0; busy_cnt = 0; timing_ok = 1'b1; finished = 1'b0;
        prev = n;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (done) begin
                finished = 1'b1;
                break;
            end
            if (busy) busy_cnt++;
            step();
            if (n !== prev) begin
                if (nsteps < 16) seen[nsteps] = n;
                if (cyc != P * nsteps + P - 1) timing_ok = 1'b0;
                nsteps++;
                prev = n;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_arg = '0; abort = 1'b0;
        step(); step();
        checks++; if (n !== 3'd0) begin errors++; $display("FAIL reset_n got %0d want 0", n); end
        checks++; if (forward !== 1'b1) begin errors++; $display("FAIL reset_forward got %b want 1", forward); end
        checks++; if ({busy, done, aborted} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {busy, done, aborted}); end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", cmd_ready); end
        reset = 1'b0;
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset got %b want 1", cmd_ready); end
    endtask

    task automatic test_load();
        issue(2'd0, 3'd5);
        checks++; if (n !== 3'd5) begin errors++; $display("FAIL load_n got %0d want 5", n); end
        checks++; if ({done, aborted} !== 2'b10) begin errors++; $display("FAIL load_done got %b want 10", {done, aborted}); end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL load_ready_finish got %b want 0", cmd_ready); end
        step();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL load_done_width got %b want 0", done); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL load_ready_back got %b want 1", cmd_ready); end
    endtask

    task automatic test_run_up_wrap();
        int ns, bc; bit tok, fin;
        issue(2'd1, 3'd1);
        run_collect(ns, bc, tok, fin);
        checks++; if (!fin) begin errors++; $display("FAIL up_timeout got no done want done"); end
        checks++; if (ns != 4) begin errors++; $display("FAIL up_steps got %0d want 4", ns); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (seen[i] !== exp_up[i]) begin errors++; $display("FAIL up_seq[%0d] got %0d want %0d", i, seen[i], exp_up[i]); end
        end
        checks++; if (bc != 8) begin errors++; $display("FAIL up_busy_cycles got %0d want 8", bc); end
        checks++; if (!tok) begin errors++; $display("FAIL up_step_timing got irregular want every %0d cycles", P); end
        checks++; if ({n, forward, aborted} !== {3'd1, 1'b1, 1'b0}) begin errors++; $display("FAIL up_end got n=%0d f=%b a=%b want n=1 f=1 a=0", n, forward, aborted); end
        step();
    endtask

    task automatic test_bounce();
        int ns, bc; bit tok, fin;
        issue(2'd0, 3'd5);
        step();
        issue(2'd3, 3'd2);
        run_collect(ns, bc, tok, fin);
        checks++; if (!fin) begin errors++; $display("FAIL bounce_timeout got no done want done"); end
        checks++; if (ns != 10) begin errors++; $display("FAIL bounce_steps got %0d want 10", ns); end
        for (int i = 0; i < 10; i++) begin
            checks++; if (seen[i] !== exp_bounce[i]) begin errors++; $display("FAIL bounce_seq[%0d] got %0d want %0d", i, seen[i], exp_bounce[i]); end
        end
        checks++; if (!tok) begin errors++; $display("FAIL bounce_step_timing got irregular want every %0d cycles", P); end
        checks++; if ({n, forward} !== {3'd1, 1'b1}) begin errors++; $display("FAIL bounce_end got n=%0d f=%b want n=1 f=1", n, forward); end
        step();
    endtask

    task automatic test_abort();
        int cyc;
        issue(2'd0, 3'd1);
        step();
        issue(2'd2, 3'd4);
        cyc = 0;
        while (n !== 3'd7 && cyc < 20) begin step(); cyc++; end
        checks++; if (n !== 3'd7) begin errors++; $display("FAIL abort_reach7 got %0d want 7", n); end
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++; if ({done, aborted} !== 2'b11) begin errors++; $display("FAIL abort_done got %b want 11", {done, aborted}); end
        checks++; if ({n, forward} !== {3'd7, 1'b0}) begin errors++; $display("FAIL abort_state got n=%0d f=%b want n=7 f=0", n, forward); end
        step();
        checks++; if ({done, aborted} !== 2'b00) begin errors++; $display("FAIL abort_clear got %b want 00", {done, aborted}); end
        step(); step(); step();
        checks++; if (n !== 3'd7) begin errors++; $display("FAIL abort_no_more_steps got %0d want 7", n); end
    endtask

    task automatic test_zero_step();
        issue(2'd0, 3'd3);
        step();
        issue(2'd1, 3'd3);
        checks++; if ({done, busy, n} !== {1'b1, 1'b0, 3'd3}) begin errors++; $display("FAIL zero_step got done=%b busy=%b n=%0d want 1 0 3", done, busy, n); end
        step();
    endtask

    task automatic test_ignored_while_busy();
        issue(2'd1, 3'd0);
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_arg = 3'd6;
        step(); step(); step();
        cmd_valid = 1'b0;
        checks++; if ({busy, n} !== {1'b1, 3'd4}) begin errors++; $display("FAIL ignored_cmd got busy=%b n=%0d want 1 4", busy, n); end
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++; if ({done, aborted, n} !== {1'b1, 1'b1, 3'd4}) begin errors++; $display("FAIL abort_over_tick got d=%b a=%b n=%0d want 1 1 4", done, aborted, n); end
        step();
    endtask

    task automatic test_reset_mid_bounce();
        int pulses;
        issue(2'd0, 3'd2);
        step();
        issue(2'd3, 3'd3);
        step(); step(); step(); step(); step();
        reset = 1'b1;
        step();
        checks++; if ({n, forward, busy, done} !== {3'd0, 1'b1, 1'b0, 1'b0}) begin errors++; $display("FAIL mid_reset got n=%0d f=%b b=%b d=%b want 0 1 0 0", n, forward, busy, done); end
        step();
        reset = 1'b0;
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_ready got %b want 1", cmd_ready); end
        pulses = 0;
        for (int i = 0; i < 10; i++) begin step(); if (done) pulses++; end
        checks++; if (pulses != 0) begin errors++; $display("FAIL mid_reset_done_pulse got %0d want 0", pulses); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_run_up_wrap();
        test_bounce();
        test_abort();
        test_zero_step();
        test_ignored_while_busy();
        test_reset_mid_bounce();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
